mix_columns_pipe: RTL and testbench

// - Parametrised, pipelined AES MixColumns / InvMixColumns engine. Each beat carries NCOLS 32-bit columns.
// - Per-beat mode select: forward, inverse, or bypass (bypass serves the final round).
// - Sits between ShiftRows/InvShiftRows and AddRoundKey in the round datapath.
// - valid/ready handshake; full throughput of 1 beat/cycle.

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/mix_column_core.sv | 22 ++
 rtl/mix_columns_pipe.sv | 131 +++++++++++++
 tb/tb_mix_columns_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared GF(2^8) helpers and mode encodings for the MixColumns datapath.
// Bytes within a column are ordered row0 at [31:24] down to row3 at [7:0].
package aes_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_FWD = 2'd0;
  localparam mode_t MODE_INV = 2'd1;
  localparam mode_t MODE_BYP = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col_fwd(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    // 3x is expressed as xtime(x) ^ x.
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Pre-mix that turns the forward mix into InvMixColumns when applied first.
  function automatic logic [31:0] inv_premix(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] u, v;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    u  = xtime(xtime(a0 ^ a2));
    v  = xtime(xtime(a1 ^ a3));
    return {a0 ^ u, a1 ^ v, a2 ^ u, a3 ^ v};
  endfunction

endpackage

// File: rtl/mix_column_core.sv
// Combinational single-column step: optional inverse pre-mix, then optional forward mix.
// PRE_EN/MIX_EN select which half of the transform this pipeline stage performs.
module mix_column_core
  import aes_pkg::*;
#(
  parameter bit PRE_EN = 1'b1,
  parameter bit MIX_EN = 1'b1
) (
  input  logic [31:0] col_i,
  input  logic        inv_i,
  input  logic        bypass_i,
  output logic [31:0] col_o
);

  logic [31:0] pre;

  always_comb begin
    pre   = (PRE_EN && inv_i && !bypass_i) ? inv_premix(col_i) : col_i;
    col_o = (MIX_EN && !bypass_i) ? mix_col_fwd(pre) : pre;
  end

endmodule

// File: rtl/mix_columns_pipe.sv
// Pipelined AES MixColumns / InvMixColumns / bypass engine, NCOLS columns per beat.
// Each stage is a valid/ready register slice; mode and tag travel with the beat.
module mix_columns_pipe
  import aes_pkg::*;
#(
  parameter int NCOLS = 4,
  parameter int PIPE  = 2,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*NCOLS-1:0]   in_data,
  input  logic                  in_inv,
  input  logic                  in_bypass,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NCOLS-1:0]   out_data,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int W = 32 * NCOLS;

  if (!(NCOLS == 1 || NCOLS == 2 || NCOLS == 4)) begin : g_bad_ncols
    $error("mix_columns_pipe: NCOLS must be 1, 2 or 4");
  end
  if (!(PIPE == 1 || PIPE == 2)) begin : g_bad_pipe
    $error("mix_columns_pipe: PIPE must be 1 or 2");
  end

  logic [PIPE-1:0]  valid_q, valid_d, stage_ready;
  logic [W-1:0]     data_q  [PIPE];
  logic [W-1:0]     data_d  [PIPE];
  logic [TAG_W-1:0] tag_q   [PIPE];
  logic [TAG_W-1:0] tag_d   [PIPE];
  mode_t            mode_q  [PIPE];
  mode_t            mode_d  [PIPE];

  // Per-stage inputs: stage 0 from the port, later stages from the previous register.
  logic             vin     [PIPE];
  logic [W-1:0]     st_in   [PIPE];
  logic [TAG_W-1:0] tag_in  [PIPE];
  mode_t            mode_in [PIPE];
  logic [31:0]      col_res [PIPE][NCOLS];
  logic [W-1:0]     st_res  [PIPE];

  for (genvar s = 0; s < PIPE; s++) begin : g_stage
    if (s == 0) begin : g_src_port
      assign vin[s]     = in_valid;
      assign st_in[s]   = in_data;
      assign tag_in[s]  = in_tag;
      assign mode_in[s] = in_bypass ? MODE_BYP : (in_inv ? MODE_INV : MODE_FWD);
    end else begin : g_src_prev
      assign vin[s]     = valid_q[s-1];
      assign st_in[s]   = data_q[s-1];
      assign tag_in[s]  = tag_q[s-1];
      assign mode_in[s] = mode_q[s-1];
    end

    for (genvar c = 0; c < NCOLS; c++) begin : g_col
      mix_column_core #(
        .PRE_EN (s == 0),
        .MIX_EN (s == PIPE - 1)
      ) u_core (
        .col_i    (st_in[s][W-1-32*c -: 32]),
        .inv_i    (mode_in[s] == MODE_INV),
        .bypass_i (mode_in[s] == MODE_BYP),
        .col_o    (col_res[s][c])
      );
    end
  end

  always_comb begin
    for (int s = 0; s < PIPE; s++) begin
      st_res[s] = '0;
      for (int c = 0; c < NCOLS; c++) begin
        st_res[s][W-1-32*c -: 32] = col_res[s][c];
      end
    end
  end

  // Ready ripples back from out_ready; a stage loads when empty or draining this cycle.
  always_comb begin
    logic nxt_ready;
    nxt_ready   = out_ready;
    stage_ready = '0;
    for (int s = PIPE - 1; s >= 0; s--) begin
      stage_ready[s] = !valid_q[s] | nxt_ready;
      nxt_ready      = stage_ready[s];
    end
    for (int s = 0; s < PIPE; s++) begin
      valid_d[s] = stage_ready[s] ? vin[s] : valid_q[s];
      if (stage_ready[s] && vin[s]) begin
        data_d[s] = st_res[s];
        tag_d[s]  = tag_in[s];
        mode_d[s] = mode_in[s];
      end else begin
        data_d[s] = data_q[s];
        tag_d[s]  = tag_q[s];
        mode_d[s] = mode_q[s];
      end
    end
  end

  // NOTE: datapath flops are reset too, because out_data/out_tag must read 0 while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < PIPE; s++) begin
        data_q[s] <= '0;
        tag_q[s]  <= '0;
        mode_q[s] <= MODE_FWD;
      end
    end else begin
      valid_q <= valid_d;
      for (int s = 0; s < PIPE; s++) begin
        data_q[s] <= data_d[s];
        tag_q[s]  <= tag_d[s];
        mode_q[s] <= mode_d[s];
      end
    end
  end

  assign in_ready  = stage_ready[0];
  assign out_valid = valid_q[PIPE-1];
  assign out_data  = data_q[PIPE-1];
  assign out_tag   = tag_q[PIPE-1];

endmodule

// File: tb/tb_mix_columns_pipe.sv
// Directed bench for mix_columns_pipe: known AES column vectors, latency, stalls,
// back-pressure fill/drain and mid-stream reset, checked against a tag/data scoreboard.
module tb_mix_columns_pipe;

  localparam int NCOLS = 4;
  localparam int PIPE  = 2;
  localparam int TAG_W = 4;
  localparam int W     = 32 * NCOLS;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_inv, in_bypass;
  logic [W-1:0]     in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  mix_columns_pipe #(.NCOLS(NCOLS), .PIPE(PIPE), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .in_bypass (in_bypass),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [W-1:0]     data;
    logic [TAG_W-1:0] tag;
    int               t_acc;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               failures = 0;
  int               cyc = 0;
  int               n_dlv = 0;
  int               first_dlv = -1;
  int               last_dlv = -1;
  bit               held_valid = 1'b0;
  logic [W-1:0]     held_data;
  logic [TAG_W-1:0] held_tag;

  // Hand-derived vectors: fwd(A)=B, inv(B)=A, inv(C)=D, fwd(D)=C.
  logic [W-1:0] v_in  [6];
  logic [W-1:0] v_exp [6];
  bit           v_inv [6];
  bit           v_byp [6];
  int           alt_tab [3] = '{0, 1, 4};

  task automatic check(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample #1 later, then advance to the next negedge.
  task automatic step(input bit vld, input int idx, input logic [TAG_W-1:0] tg,
                      input bit ordy, input bit chk_lat, output bit acc);
    exp_t e;
    in_valid  = vld;
    in_data   = v_in[idx];
    in_inv    = v_inv[idx];
    in_bypass = v_byp[idx];
    in_tag    = tg;
    out_ready = ordy;
    #1;
    if (held_valid) begin
      check("hold_valid", W'(out_valid), W'(1));
      check("hold_data", out_data, held_data);
      check("hold_tag", W'(out_tag), W'(held_tag));
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("no_spurious_beat", W'(out_valid), W'(0));
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_tag", W'(out_tag), W'(e.tag));
        if (chk_lat) check("latency", W'(cyc - e.t_acc), W'(PIPE));
        n_dlv++;
        if (first_dlv < 0) first_dlv = cyc;
        last_dlv = cyc;
      end
    end
    held_valid = out_valid && !out_ready;
    held_data  = out_data;
    held_tag   = out_tag;
    acc = in_valid && in_ready;
    if (acc) begin
      e.data  = v_exp[idx];
      e.tag   = tg;
      e.t_acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic one_beat(input int idx, input logic [TAG_W-1:0] tg);
    bit acc;
    step(1'b1, idx, tg, 1'b1, 1'b1, acc);
    check("one_beat_accepted", W'(acc), W'(1));
    #1;
    check("one_beat_not_early", W'(out_valid), W'(0));
    for (int i = 0; i < PIPE + 4 && sb.size() != 0; i++) step(1'b0, 0, '0, 1'b1, 1'b1, acc);
    check("one_beat_delivered", W'(sb.size()), W'(0));
  endtask

  task automatic run_stream(input int n, input int stall_pct, input int idle_pct,
                            input bit alt_modes, input bit chk_lat);
    int sent = 0;
    int budget = 0;
    int d0 = n_dlv;
    int idx = 0;
    bit pending = 1'b0;
    bit vld, ordy, acc;
    first_dlv = -1;
    while ((sent < n || sb.size() != 0) && budget < n * 10 + 50) begin
      if (!pending) begin
        idx = alt_modes ? alt_tab[sent % 3] : int'($urandom_range(0, 5));
        vld = (sent < n) && ($urandom_range(0, 99) >= idle_pct);
      end
      ordy = ($urandom_range(0, 99) >= stall_pct);
      step(vld, idx, sent[TAG_W-1:0], ordy, chk_lat, acc);
      pending = vld && !acc;
      if (acc) sent++;
      budget++;
    end
    check("stream_sent", W'(sent), W'(n));
    check("stream_delivered", W'(n_dlv - d0), W'(n));
    check("stream_sb_empty", W'(sb.size()), W'(0));
    if (stall_pct == 0 && idle_pct == 0) check("stream_one_per_cycle", W'(last_dlv - first_dlv), W'(n - 1));
  endtask

  initial begin
    bit acc;
    int nacc;

    v_in[0] = 128'hdb135345_f20a225c_c6c6c6c6_2d26314c; v_inv[0] = 0; v_byp[0] = 0;
    v_exp[0] = 128'h8e4da1bc_9fdc589d_c6c6c6c6_4d7ebdf8;
    v_in[1] = 128'h8e4da1bc_9fdc589d_c6c6c6c6_4d7ebdf8; v_inv[1] = 1; v_byp[1] = 0;
    v_exp[1] = 128'hdb135345_f20a225c_c6c6c6c6_2d26314c;
    v_in[2] = 128'hdb135345_f20a225c_01010101_d4d4d4d5; v_inv[2] = 0; v_byp[2] = 0;
    v_exp[2] = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    v_in[3] = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6; v_inv[3] = 1; v_byp[3] = 0;
    v_exp[3] = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    v_in[4] = 128'hdb135345_f20a225c_c6c6c6c6_2d26314c; v_inv[4] = 0; v_byp[4] = 1;
    v_exp[4] = 128'hdb135345_f20a225c_c6c6c6c6_2d26314c;
    v_in[5] = 128'h8e4da1bc_9fdc589d_c6c6c6c6_4d7ebdf8; v_inv[5] = 1; v_byp[5] = 1;
    v_exp[5] = 128'h8e4da1bc_9fdc589d_c6c6c6c6_4d7ebdf8;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; in_bypass = 1'b0;
    in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_out_data", out_data, '0);
    check("reset_out_tag", W'(out_tag), W'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", W'(in_ready), W'(1));
    @(negedge clk);

    one_beat(0, 4'd5);
    one_beat(3, 4'd6);
    one_beat(5, 4'd7);

    run_stream(9, 0, 0, 1'b1, 1'b1);

    nacc = 0;
    for (int i = 0; i < PIPE + 2; i++) begin
      step(1'b1, 2, TAG_W'(i), 1'b0, 1'b0, acc);
      if (acc) nacc++;
    end
    check("fill_accepted", W'(nacc), W'(PIPE));
    #1;
    check("fill_in_ready_low", W'(in_ready), W'(0));
    for (int i = 0; i < PIPE + 4 && sb.size() != 0; i++) step(1'b0, 0, '0, 1'b1, 1'b0, acc);
    check("drain_complete", W'(sb.size()), W'(0));

    run_stream(1000, 30, 20, 1'b0, 1'b0);

    step(1'b1, 0, 4'd1, 1'b0, 1'b0, acc);
    step(1'b1, 1, 4'd2, 1'b0, 1'b0, acc);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_out_data", out_data, '0);
    check("midrst_out_tag", W'(out_tag), W'(0));
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    held_valid = 1'b0;
    #1;
    check("midrst_in_ready", W'(in_ready), W'(1));
    check("midrst_no_output", W'(out_valid), W'(0));
    @(negedge clk);
    one_beat(0, 4'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
